// File: rtl/pos_cache_mu_scheduler.sv
// pos_cache_mu_scheduler: sequences the motion-update pass over all caches; `define MU_SCHED_STATS_EN adds pass statistics
module pos_cache_mu_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int PARTICLE_NUM   = 220,
  parameter int CELL_ID_WIDTH  = 4,
  parameter int NUM_CELLS      = 8,
  parameter int CELL_IDX_WIDTH = 3,
  parameter int OUTST_WIDTH    = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        out_busy,
  output logic                        out_done,
  output logic                        out_motion_update_enable,
  output logic [ADDR_WIDTH-1:0]       out_rd_addr,
  output logic [NUM_CELLS-1:0]        out_rden,
  input  logic [3*DATA_WIDTH-1:0]     in_rd_data,
  output logic [3*DATA_WIDTH-1:0]     out_mu_data,
  output logic                        out_mu_valid,
  output logic [CELL_IDX_WIDTH-1:0]   out_mu_cell_idx,
  input  logic [3*DATA_WIDTH-1:0]     in_mu_result,
  input  logic [3*CELL_ID_WIDTH-1:0]  in_mu_dst_cell,
  input  logic                        in_mu_result_valid,
  output logic [3*DATA_WIDTH-1:0]     out_bcast_data,
  output logic [3*CELL_ID_WIDTH-1:0]  out_bcast_dst_cell,
  output logic                        out_bcast_valid,
  output logic                        out_err
`ifdef MU_SCHED_STATS_EN
  ,
  output logic [31:0]                 out_stat_cycles,
  output logic [OUTST_WIDTH-1:0]      out_stat_particles
`endif
);
  typedef enum logic [2:0] {IDLE, RD_COUNT, WAIT_COUNT, STREAM, NEXT_CELL, DRAIN, SETTLE} state_t;
  localparam logic [ADDR_WIDTH-1:0] PMAX = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [CELL_IDX_WIDTH-1:0] LAST = CELL_IDX_WIDTH'(NUM_CELLS - 1);
  state_t state, state_nx;
  logic [CELL_IDX_WIDTH-1:0] idx, idx_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx, p, p_nx, raw_cnt, clamp_cnt;
  logic settle, settle_nx, busy_nx, en_nx, done_nx;
  logic [OUTST_WIDTH-1:0] outst;
  assign raw_cnt = in_rd_data[ADDR_WIDTH-1:0];
  assign clamp_cnt = raw_cnt > PMAX ? PMAX : raw_cnt;
  assign out_rden = (state == RD_COUNT || state == STREAM) ? NUM_CELLS'(1) << idx : '0;
  assign out_rd_addr = state == STREAM ? p : '0;
  assign out_mu_data = out_mu_valid ? in_rd_data : '0;
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    cnt_nx = cnt;
    p_nx = p;
    settle_nx = settle;
    busy_nx = out_busy;
    en_nx = out_motion_update_enable;
    done_nx = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = RD_COUNT;
        idx_nx = '0;
        busy_nx = 1'b1;
        en_nx = 1'b1;
      end
      RD_COUNT: state_nx = WAIT_COUNT;
      WAIT_COUNT: begin
        cnt_nx = clamp_cnt;
        p_nx = ADDR_WIDTH'(1);
        state_nx = clamp_cnt == '0 ? NEXT_CELL : STREAM;
      end
      STREAM: begin
        p_nx = p + 1'b1;
        state_nx = p == cnt ? NEXT_CELL : STREAM;
      end
      NEXT_CELL: begin
        state_nx = idx == LAST ? DRAIN : RD_COUNT;
        idx_nx = idx == LAST ? idx : idx + 1'b1;
      end
      // release enable only once nothing is in flight and the last broadcast has cleared
      DRAIN: if (outst == '0 && !out_bcast_valid) begin
        en_nx = 1'b0;
        settle_nx = 1'b0;
        state_nx = SETTLE;
      end
      SETTLE: begin
        settle_nx = 1'b1;
        done_nx = settle;
        busy_nx = !settle;
        state_nx = settle ? IDLE : SETTLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      p <= '0;
      settle <= 1'b0;
      out_busy <= 1'b0;
      out_motion_update_enable <= 1'b0;
      out_done <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cnt <= cnt_nx;
      p <= p_nx;
      settle <= settle_nx;
      out_busy <= busy_nx;
      out_motion_update_enable <= en_nx;
      out_done <= done_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mu_valid <= 1'b0;
      out_mu_cell_idx <= '0;
      out_bcast_valid <= 1'b0;
      out_bcast_data <= '0;
      out_bcast_dst_cell <= '0;
      outst <= '0;
      out_err <= 1'b0;
    end else begin
      out_mu_valid <= state == STREAM;
      out_mu_cell_idx <= idx;
      out_bcast_valid <= in_mu_result_valid;
      if (in_mu_result_valid) begin
        out_bcast_data <= in_mu_result;
        out_bcast_dst_cell <= in_mu_dst_cell;
      end
      if (out_mu_valid && !in_mu_result_valid) begin
        if (&outst) out_err <= 1'b1;
        else outst <= outst + 1'b1;
      end else if (!out_mu_valid && in_mu_result_valid) begin
        if (outst == '0) out_err <= 1'b1;
        else outst <= outst - 1'b1;
      end
      if (in_mu_result_valid && !out_busy) out_err <= 1'b1;
    end
  end
`ifdef MU_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      out_stat_cycles <= '0;
      out_stat_particles <= '0;
    end else begin
      out_stat_cycles <= out_stat_cycles + 32'(out_busy);
      out_stat_particles <= out_stat_particles + OUTST_WIDTH'(out_mu_valid);
    end
  end
`endif
endmodule

// File: tb/tb_pos_cache_mu_scheduler.sv
// tb_pos_cache_mu_scheduler: directed bench with a two-cache memory model and a motion-update latency model
module tb_pos_cache_mu_scheduler;
  logic clk, rst, start;
  logic out_busy, out_done, out_en, out_mu_valid, out_bcast_valid, out_err;
  logic [7:0] out_rd_addr;
  logic [1:0] out_rden;
  logic [95:0] rd_data, out_mu_data, out_bcast_data, man_data, mdl_data, in_mu_result;
  logic [0:0] out_mu_cell_idx;
  logic [11:0] man_dst, mdl_dst, in_mu_dst_cell, out_bcast_dst_cell;
  logic man_valid, in_mu_result_valid;
  logic mdl_valid = 1'b0;
  logic model_on, lat_var;
`ifdef MU_SCHED_STATS_EN
  logic [31:0] out_stat_cycles;
  logic [9:0] out_stat_particles;
`endif
  int counts[2];
  int n_asrt, n_fail;
  int n_mu, n_mu_c1, n_prd0, n_prd1, n_crd0, n_crd1, seq_err, data_err, bc_err, n_bc, en_viol, n_done, n_busy, n_res;
  int s_mu, s_mu_c1, s_prd0, s_prd1, s_crd0, s_crd1, s_seq, s_data, s_bc, s_bcn, s_en, s_done, s_busy, s_res;
  logic [7:0] last_addr0, exp_addr, prev_addr;
  logic prev_cell;

  assign in_mu_result_valid = man_valid | mdl_valid;
  assign in_mu_result = man_valid ? man_data : mdl_data;
  assign in_mu_dst_cell = man_valid ? man_dst : mdl_dst;

  pos_cache_mu_scheduler #(.NUM_CELLS(2), .CELL_IDX_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .start(start), .out_busy(out_busy), .out_done(out_done),
    .out_motion_update_enable(out_en), .out_rd_addr(out_rd_addr), .out_rden(out_rden),
    .in_rd_data(rd_data), .out_mu_data(out_mu_data), .out_mu_valid(out_mu_valid),
    .out_mu_cell_idx(out_mu_cell_idx), .in_mu_result(in_mu_result), .in_mu_dst_cell(in_mu_dst_cell),
    .in_mu_result_valid(in_mu_result_valid), .out_bcast_data(out_bcast_data),
    .out_bcast_dst_cell(out_bcast_dst_cell), .out_bcast_valid(out_bcast_valid), .out_err(out_err)
`ifdef MU_SCHED_STATS_EN
    , .out_stat_cycles(out_stat_cycles), .out_stat_particles(out_stat_particles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] word(input logic c, input logic [7:0] a);
    return {31'd0, c, 24'd0, a, 32'hC0DE_0000};
  endfunction
  function automatic logic [95:0] cword(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {64'h1234_5678_9ABC_DEF0, 24'hABCDEF, b};
  endfunction

  // cache pair: count at address 0 (with junk above the address bits), positions elsewhere
  always @(posedge clk)
    rd_data <= out_rden == 2'b01 ? (out_rd_addr == 0 ? cword(counts[0]) : word(1'b0, out_rd_addr)) :
               out_rden == 2'b10 ? (out_rd_addr == 0 ? cword(counts[1]) : word(1'b1, out_rd_addr)) : '0;

  // motion update unit: fixed 4-cycle or varied 1..20-cycle latency, one result per cycle
  logic [95:0] pd[256];
  logic [11:0] pdst[256];
  int pdue[256];
  int np, cyc, seqn;
  always @(negedge clk) begin
    int k;
    cyc++;
    if (!model_on) np = 0;
    else if (out_mu_valid) begin
      pd[np] = out_mu_data ^ 96'h5;
      pdst[np] = 12'(seqn * 37 + 1);
      pdue[np] = cyc + (lat_var ? (seqn * 7) % 20 + 1 : 4);
      seqn++;
      np++;
    end
    #1;
    k = -1;
    for (int i = 0; i < np; i++) if (k < 0 && pdue[i] <= cyc) k = i;
    mdl_valid = k >= 0;
    if (k >= 0) begin
      mdl_data = pd[k];
      mdl_dst = pdst[k];
      for (int j = k; j < np - 1; j++) begin
        pd[j] = pd[j + 1];
        pdst[j] = pdst[j + 1];
        pdue[j] = pdue[j + 1];
      end
      np--;
    end
  end

  always @(negedge clk) begin
    if (out_busy) n_busy++;
    if (out_done) n_done++;
    if (out_mu_valid) begin
      n_mu++;
      if (out_mu_cell_idx == 1'b1) n_mu_c1++;
      if (out_mu_data !== word(prev_cell, prev_addr)) data_err++;
    end
    if (out_rden[0]) begin
      if (out_rd_addr == 0) n_crd0++;
      else begin
        n_prd0++;
        last_addr0 = out_rd_addr;
      end
    end
    if (out_rden[1]) begin
      if (out_rd_addr == 0) n_crd1++;
      else n_prd1++;
    end
    if (out_rden == 2'b11) seq_err++;
    if (out_rden != 0) begin
      if (out_rd_addr == 0) exp_addr = 8'd1;
      else begin
        if (out_rd_addr != exp_addr) seq_err++;
        exp_addr++;
      end
    end
    prev_cell = out_rden[1];
    prev_addr = out_rd_addr;
    if (!rst) begin
      if (in_mu_result_valid) begin
        n_res++;
        if (!out_bcast_valid || out_bcast_data !== in_mu_result || out_bcast_dst_cell !== in_mu_dst_cell) bc_err++;
      end else if (out_bcast_valid) bc_err++;
    end
    if (out_bcast_valid) n_bc++;
    if (out_busy && out_bcast_valid && !out_en) en_viol++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_mu = n_mu; s_mu_c1 = n_mu_c1; s_prd0 = n_prd0; s_prd1 = n_prd1; s_crd0 = n_crd0; s_crd1 = n_crd1;
    s_seq = seq_err; s_data = data_err; s_bc = bc_err; s_bcn = n_bc; s_en = en_viol; s_done = n_done;
    s_busy = n_busy; s_res = n_res;
  endtask

  task automatic wait_done(input int bound, output int en_to_done);
    int t, t_fall, t_done;
    logic en_prev;
    t = 0; t_fall = -1; t_done = -1; en_prev = out_en;
    while (t < bound && t_done < 0) begin
      tick();
      t++;
      if (en_prev && !out_en) t_fall = t;
      en_prev = out_en;
      if (out_done) t_done = t;
    end
    chk("done_seen", 128'(t_done >= 0), 128'(1));
    en_to_done = t_done - t_fall;
  endtask

  task automatic run_pass(input int c0, input int c1, output int en_to_done);
    counts[0] = c0;
    counts[1] = c1;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", out_busy, 1);
    chk("enable_after_start", out_en, 1);
    wait_done(2000, en_to_done);
    chk("busy_clear_at_done", out_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    logic found;
    rst = 1'b1; start = 1'b0; man_valid = 1'b0; man_data = '0; man_dst = '0;
    model_on = 1'b1; lat_var = 1'b0; counts[0] = 0; counts[1] = 0;
    repeat (3) tick();
    chk("rst_busy", out_busy, 0);
    chk("rst_done", out_done, 0);
    chk("rst_enable", out_en, 0);
    chk("rst_rden", out_rden, 0);
    chk("rst_rd_addr", out_rd_addr, 0);
    chk("rst_mu_valid", out_mu_valid, 0);
    chk("rst_mu_data", out_mu_data, 0);
    chk("rst_mu_cell_idx", out_mu_cell_idx, 0);
    chk("rst_bcast_valid", out_bcast_valid, 0);
    chk("rst_bcast_data", out_bcast_data, 0);
    chk("rst_bcast_dst", out_bcast_dst_cell, 0);
    chk("rst_err", out_err, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", out_busy, 0);

    // counts 3 and 0 with a 4-cycle unit
    run_pass(3, 0, d);
    chk("p1_mu_pulses", n_mu - s_mu, 3);
    chk("p1_mu_cell1", n_mu_c1 - s_mu_c1, 0);
    chk("p1_reads_c0", n_prd0 - s_prd0, 3);
    chk("p1_last_addr_c0", last_addr0, 3);
    chk("p1_reads_c1", n_prd1 - s_prd1, 0);
    chk("p1_count_reads_c0", n_crd0 - s_crd0, 1);
    chk("p1_count_reads_c1", n_crd1 - s_crd1, 1);
    chk("p1_addr_seq", seq_err - s_seq, 0);
    chk("p1_mu_data", data_err - s_data, 0);
    chk("p1_bcast", bc_err - s_bc, 0);
    chk("p1_bcast_count", n_bc - s_bcn, 3);
    chk("p1_en_to_done", d, 2);
    chk("p1_busy_cycles", n_busy - s_busy, 14);
    chk("p1_done_pulses", n_done - s_done, 1);
    chk("p1_err", out_err, 0);

    // count above PARTICLE_NUM is clamped
    run_pass(250, 0, d);
    chk("p2_reads_c0", n_prd0 - s_prd0, 220);
    chk("p2_last_addr_c0", last_addr0, 220);
    chk("p2_mu_pulses", n_mu - s_mu, 220);
    chk("p2_addr_seq", seq_err - s_seq, 0);
    chk("p2_bcast", bc_err - s_bc, 0);
    chk("p2_err", out_err, 0);

    // out-of-order returns with latencies 1..20
    lat_var = 1'b1;
    run_pass(5, 4, d);
    lat_var = 1'b0;
    chk("p3_results", n_res - s_res, 9);
    chk("p3_bcast_count", n_bc - s_bcn, 9);
    chk("p3_bcast", bc_err - s_bc, 0);
    chk("p3_enable_cover", en_viol - s_en, 0);
    chk("p3_mu_cell1", n_mu_c1 - s_mu_c1, 4);
    chk("p3_mu_data", data_err - s_data, 0);
    chk("p3_en_to_done", d, 2);
    chk("p3_err", out_err, 0);

    // issue and return in the same cycle at outstanding 5
    model_on = 1'b0;
    counts[0] = 8; counts[1] = 0;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      found = out_mu_valid && dut.outst == 10'd5;
    end
    chk("p4_reach_outst5", found, 1);
    man_valid = 1'b1; man_data = 96'hFEED_0001; man_dst = 12'h123;
    tick();
    man_valid = 1'b0;
    chk("p4_outst_same_cycle", dut.outst, 5);
    repeat (5) tick();
    chk("p4_outst_after_stream", dut.outst, 7);
    chk("p4_enable_held", out_en, 1);
    for (int i = 0; i < 7; i++) begin
      man_valid = 1'b1; man_data = 96'hFEED_0100 + 96'(i); man_dst = 12'(i + 1);
      tick();
    end
    man_valid = 1'b0;
    wait_done(100, d);
    chk("p4_en_to_done", d, 2);
    chk("p4_err", out_err, 0);
    chk("p4_bcast", bc_err - s_bc, 0);
    chk("p4_done_pulses", n_done - s_done, 1);

    // spurious result in IDLE
    repeat (2) tick();
    man_valid = 1'b1; man_data = 96'hABC; man_dst = 12'h321;
    tick();
    man_valid = 1'b0;
    chk("idle_bcast_valid", out_bcast_valid, 1);
    chk("idle_bcast_data", out_bcast_data, 96'hABC);
    chk("idle_bcast_dst", out_bcast_dst_cell, 12'h321);
    chk("idle_err_set", out_err, 1);
    tick();
    chk("err_sticky", out_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("err_cleared_by_rst", out_err, 0);
    model_on = 1'b1;

    // start while busy is ignored
    counts[0] = 2; counts[1] = 1;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, d);
    repeat (30) tick();
    chk("p5_single_done", n_done - s_done, 1);
    chk("p5_mu_pulses", n_mu - s_mu, 3);
    chk("p5_idle_after", out_busy, 0);

    // reset mid-stream aborts without done
    counts[0] = 10; counts[1] = 0;
    snap();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      found = out_rden[0] && out_rd_addr == 8'd4;
    end
    chk("p6_reach_addr4", found, 1);
    model_on = 1'b0;
    rst = 1'b1;
    tick();
    chk("p6_rst_busy", out_busy, 0);
    chk("p6_rst_outputs", {out_done, out_en, out_rden, out_rd_addr, out_mu_valid, out_mu_data, out_mu_cell_idx,
                           out_bcast_valid, out_bcast_data, out_bcast_dst_cell, out_err}, 0);
    rst = 1'b0;
    repeat (30) tick();
    chk("p6_no_done", n_done - s_done, 0);
    chk("p6_err", out_err, 0);
    model_on = 1'b1;
    tick();

`ifdef MU_SCHED_STATS_EN
    run_pass(2, 2, d);
    chk("stat_particles", out_stat_particles, 4);
    chk("stat_cycles", out_stat_cycles, 32'(n_busy - s_busy));
    repeat (3) tick();
    chk("stat_frozen", out_stat_cycles, 32'(n_busy - s_busy));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
